// File: rtl/prbs_descrambler_pkg.sv
// Shared definitions for the PRBS7 descrambler and its keystream generator.
// The transmit scrambler imports the same package so both ends agree on taps and seed.
package prbs_descrambler_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;

  localparam logic [6:0] DEFAULT_SEED = 7'h7F;

  typedef struct packed {
    logic sof;
    logic eof;
  } frame_marker_t;

  function automatic logic prbs7_feedback(input logic [6:0] state);
    return state[PRBS_TAP_HI] ^ state[PRBS_TAP_LO];
  endfunction

endpackage

// File: rtl/prbs_descrambler_if.sv
// Byte stream with valid/ready handshake and frame markers.
// The producer side uses the master modport, the consumer side uses the slave modport.
interface prbs_descrambler_if;

  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       sof;
  logic       eof;

  modport master (
    output valid,
    output data,
    output sof,
    output eof,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  sof,
    input  eof,
    output ready
  );

endinterface

// File: rtl/prbs_descrambler_prbs7_keystream.sv
// Combinational PRBS7 keystream: one key byte (LSB generated first) and the LFSR state after it.
// Shared with the transmit scrambler, so it has no clock and no framing knowledge.
module prbs7_keystream
  import prbs_descrambler_pkg::*;
(
  input  logic [6:0] i_state,
  output logic [7:0] o_key,
  output logic [6:0] o_next_state
);

  // Unroll eight LFSR steps; each step's feedback bit is also the key bit.
  always_comb begin
    logic [6:0] v_state;
    logic [7:0] v_key;
    logic       v_bit;
    v_state = i_state;
    v_key   = 8'h00;
    v_bit   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v_bit    = prbs7_feedback(v_state);
      v_key[i] = v_bit;
      v_state  = {v_state[5:0], v_bit};
    end
    o_key        = v_key;
    o_next_state = v_state;
  end

endmodule

// File: rtl/prbs_descrambler.sv
// Byte-wide additive PRBS7 descrambler with a single no-bubble output register,
// framing-error detection and a last-completed-frame length report.
module prbs_descrambler
  import prbs_descrambler_pkg::*;
#(
  parameter logic [6:0] SEED      = DEFAULT_SEED,
  parameter int         LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prbs_descrambler_if.slave    in_if,
  prbs_descrambler_if.master   out_if,
  input  logic                 i_err_clr,
  output logic [LEN_WIDTH-1:0] o_frame_len,
  output logic                 o_err
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic                 w_xfer;
  logic                 w_drop;
  logic                 w_accept;
  logic                 w_restart;
  logic                 w_err_set;
  logic [6:0]           w_key_state;
  logic [6:0]           w_next_lfsr;
  logic [7:0]           w_key;
  logic [LEN_WIDTH-1:0] w_len_next;

  state_e               r_state;
  logic [6:0]           r_lfsr;
  logic                 r_out_valid;
  logic [7:0]           r_out_data;
  frame_marker_t        r_out_mark;
  logic [LEN_WIDTH-1:0] r_len_cnt;
  logic [LEN_WIDTH-1:0] r_frame_len;
  logic                 r_err;

  // The output register can take a new byte whenever it is empty or being drained.
  assign in_if.ready = !r_out_valid || out_if.ready;
  assign w_xfer      = in_if.valid && in_if.ready;
  assign w_drop      = w_xfer && (r_state == IDLE) && !in_if.sof;
  assign w_accept    = w_xfer && !w_drop;
  assign w_restart   = w_accept && (r_state == ACTIVE) && in_if.sof;
  assign w_err_set   = w_drop || w_restart;
  assign w_key_state = in_if.sof ? SEED : r_lfsr;

  prbs7_keystream u_keystream (
    .i_state      (w_key_state),
    .o_key        (w_key),
    .o_next_state (w_next_lfsr)
  );

  // Next frame length: restart at one on Sof, otherwise count up and stick at all-ones.
  always_comb begin
    w_len_next = r_len_cnt;
    if (in_if.sof) begin
      w_len_next = LEN_ONE;
    end else if (&r_len_cnt) begin
      w_len_next = r_len_cnt;
    end else begin
      w_len_next = r_len_cnt + LEN_ONE;
    end
  end

  // Frame FSM, keystream state and the output register advance together on accepted bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lfsr      <= SEED;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_mark  <= '{sof: 1'b0, eof: 1'b0};
    end else begin
      if (w_accept) begin
        case (r_state)
          IDLE:    r_state <= in_if.eof ? IDLE : ACTIVE;
          ACTIVE:  r_state <= in_if.eof ? IDLE : ACTIVE;
          default: r_state <= IDLE;
        endcase
        r_lfsr      <= w_next_lfsr;
        r_out_valid <= 1'b1;
        r_out_data  <= in_if.data ^ w_key;
        r_out_mark  <= '{sof: in_if.sof, eof: in_if.eof};
      end else if (out_if.ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Length bookkeeping and the sticky error flag; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_cnt   <= {LEN_WIDTH{1'b0}};
      r_frame_len <= {LEN_WIDTH{1'b0}};
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_len_cnt <= w_len_next;
        if (in_if.eof) begin
          r_frame_len <= w_len_next;
        end
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_if.valid = r_out_valid;
  assign out_if.data  = r_out_data;
  assign out_if.sof   = r_out_mark.sof;
  assign out_if.eof   = r_out_mark.eof;
  assign o_frame_len  = r_frame_len;
  assign o_err        = r_err;

endmodule

// File: tb/tb_prbs_descrambler.sv
// Self-checking bench for prbs_descrambler: directed vector table, corner-case sequences
// and a randomized stream compared against a bit-recurrence keystream model.
module tb_prbs_descrambler;
  import prbs_descrambler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] frame_len;
  logic        err;

  prbs_descrambler_if in_bus ();
  prbs_descrambler_if out_bus ();

  prbs_descrambler #(.SEED(7'h7F), .LEN_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (in_bus.slave),
    .out_if      (out_bus.master),
    .i_err_clr   (err_clr),
    .o_frame_len (frame_len),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  logic seq_bits [0:7+8*64-1];

  typedef struct {
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic        exp_valid;
    logic [7:0]  exp_d;
    logic        exp_sof;
    logic        exp_eof;
    logic        chk_len;
    logic [15:0] exp_len;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } item_t;

  vec_t       vecs [6];
  item_t      items [$];
  logic [9:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Key byte j of a frame: bits 7+8j .. 7+8j+7 of the PRBS7 bit sequence, LSB first.
  function automatic logic [7:0] key_at(input int j);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) k[i] = seq_bits[7 + 8 * j + i];
    return k;
  endfunction

  task automatic drive_idle();
    in_bus.valid = 1'b0;
    in_bus.data  = 8'h00;
    in_bus.sof   = 1'b0;
    in_bus.eof   = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic eof);
    in_bus.valid = 1'b1;
    in_bus.data  = d;
    in_bus.sof   = sof;
    in_bus.eof   = eof;
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic send_chk(input string name, input logic [7:0] d, input logic sof,
                          input logic eof, input int kidx);
    send(d, sof, eof);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_bus.valid), 32'd1);
    check({name, "_data"}, {22'd0, out_bus.data, out_bus.sof, out_bus.eof},
          {22'd0, d ^ key_at(kidx), sof, eof});
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] seed_v;
    logic [7:0] rd;
    int         idx;
    int         cyc;
    int         m_active;
    int         m_idx;
    int         m_cnt;
    int         m_last;
    logic       m_err;
    int         flen;
    logic       b_sof;

    // Reference keystream: seed bits are the seven bits "before" the frame, then b[n] = b[n-7]^b[n-6].
    seed_v = 7'h7F;
    for (int n = 0; n < 7; n++) seq_bits[n] = seed_v[6 - n];
    for (int n = 7; n < 7 + 8 * 64; n++) seq_bits[n] = seq_bits[n - 7] ^ seq_bits[n - 6];

    vecs[0] = '{8'h40, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[1] = '{8'h30, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hBF, 1'b1, 1'b1, 1'b1, 16'd1, 1'b0};
    vecs[3] = '{8'h40, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
    vecs[4] = '{8'h30, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0};
    vecs[5] = '{8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1};

    drive_idle();
    out_bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", {22'd0, out_bus.valid, out_bus.data, out_bus.sof}, 32'd0);
    check("rst_eof", 32'(out_bus.eof), 32'd0);
    check("rst_len", 32'(frame_len), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_bus.ready), 32'd1);
    rst_n = 1'b1;

    // Directed table, one transfer per entry with the sink always ready.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].d, vecs[v].sof, vecs[v].eof);
      @(negedge clk);
      check("vec_valid", 32'(out_bus.valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid)
        check("vec_data", {22'd0, out_bus.data, out_bus.sof, out_bus.eof},
              {22'd0, vecs[v].exp_d, vecs[v].exp_sof, vecs[v].exp_eof});
      if (vecs[v].chk_len) check("vec_len", 32'(frame_len), 32'(vecs[v].exp_len));
      check("vec_err", 32'(err), 32'(vecs[v].exp_err));
    end

    // Err clear, then clear colliding with a new error.
    pulse_clr();
    check("err_clr", 32'(err), 32'd0);
    in_bus.valid = 1'b1;
    in_bus.data  = 8'h55;
    err_clr      = 1'b1;
    @(posedge clk);
    #1;
    drive_idle();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_collide", 32'(err), 32'd1);
    check("drop_no_valid", 32'(out_bus.valid), 32'd0);
    pulse_clr();
    check("err_clr2", 32'(err), 32'd0);

    // Backpressure: second byte must wait while the first sits in the output register.
    out_bus.ready = 1'b0;
    in_bus.valid  = 1'b1;
    in_bus.data   = 8'hA5;
    in_bus.sof    = 1'b1;
    @(posedge clk);
    #1;
    in_bus.data = 8'h3C;
    in_bus.sof  = 1'b0;
    in_bus.eof  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_bus.ready), 32'd0);
      check("bp_hold", {22'd0, out_bus.valid, out_bus.data, out_bus.sof}, {22'd0, 1'b1, 8'hE5, 1'b1});
      @(posedge clk);
      #1;
    end
    out_bus.ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(in_bus.ready), 32'd1);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check("bp_second", {22'd0, out_bus.valid, out_bus.data, out_bus.sof, out_bus.eof},
          {22'd0, 1'b1, 8'h0C, 1'b0, 1'b1});
    check("bp_len", 32'(frame_len), 32'd2);

    // Sof arriving mid-frame after three bytes restarts the keystream and the length.
    for (int b = 0; b < 3; b++) begin
      rd = 8'($urandom);
      send_chk("mid_pre", rd, (b == 0), 1'b0, b);
    end
    check("mid_err_before", 32'(err), 32'd0);
    send_chk("mid_restart", 8'h40, 1'b1, 1'b0, 0);
    check("mid_restart_key", 32'(out_bus.data), 32'h00);
    check("mid_err", 32'(err), 32'd1);
    send_chk("mid_tail", 8'h30, 1'b0, 1'b1, 1);
    check("mid_len", 32'(frame_len), 32'd2);

    // Reset while the second byte of a frame is presented.
    send(8'h40, 1'b1, 1'b0);
    in_bus.valid = 1'b1;
    in_bus.data  = 8'h30;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_bus.valid), 32'd0);
    check("rst_mid_len", 32'(frame_len), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h30, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_need_sof", {30'd0, out_bus.valid, err}, {30'd0, 1'b0, 1'b1});
    send_chk("rst_new_a", 8'h40, 1'b1, 1'b0, 0);
    check("rst_new_a_key", 32'(out_bus.data), 32'h00);
    send_chk("rst_new_b", 8'h30, 1'b0, 1'b1, 1);
    check("rst_new_len", 32'(frame_len), 32'd2);
    pulse_clr();

    // Randomized stream with stray bytes and restarts, random gaps and random backpressure.
    while (items.size() < 200) begin
      if ($urandom_range(0, 9) == 0) items.push_back('{8'($urandom), 1'b0, 1'b0});
      flen = $urandom_range(1, 12);
      for (int b = 0; b < flen; b++) begin
        b_sof = (b == 0) || ($urandom_range(0, 24) == 0);
        items.push_back('{8'($urandom), b_sof, (b == flen - 1)});
      end
    end
    m_active = 0;
    m_idx    = 0;
    m_cnt    = 0;
    m_last   = 0;
    m_err    = 1'b0;
    foreach (items[i]) begin
      if (m_active == 0 && !items[i].sof) begin
        m_err = 1'b1;
      end else begin
        if (items[i].sof) begin
          if (m_active != 0) m_err = 1'b1;
          m_idx = 0;
          m_cnt = 1;
        end else begin
          m_cnt++;
        end
        exp_q.push_back({items[i].d ^ key_at(m_idx), items[i].sof, items[i].eof});
        m_idx++;
        if (items[i].eof) begin
          m_active = 0;
          m_last   = m_cnt;
        end else begin
          m_active = 1;
        end
      end
    end

    idx = 0;
    cyc = 0;
    while ((idx < items.size() || exp_q.size() > 0) && cyc < 5000) begin
      out_bus.ready = ($urandom_range(0, 2) != 0);
      if (idx < items.size() && $urandom_range(0, 4) != 0) begin
        in_bus.valid = 1'b1;
        in_bus.data  = items[idx].d;
        in_bus.sof   = items[idx].sof;
        in_bus.eof   = items[idx].eof;
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (out_bus.valid && out_bus.ready) begin
        if (exp_q.size() == 0) check("rand_extra", 32'(out_bus.data), 32'hFFFF_FFFF);
        else check("rand_out", {22'd0, out_bus.data, out_bus.sof, out_bus.eof}, {22'd0, exp_q.pop_front()});
      end
      if (in_bus.valid && in_bus.ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rand_timeout", 32'(cyc < 5000), 32'd1);
    drive_idle();
    out_bus.ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rand_len", 32'(frame_len), 32'(m_last));
    check("rand_err", 32'(err), 32'(m_err));
    check("rand_drained", 32'(out_bus.valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
